// File: rtl/vga_sync_decoder.sv
// Receive-side VGA timing recovery: turns a sampled hsync/vsync/DE stream into
// pixel coordinates, line/frame strobes, measured geometry and a mode-lock flag.
module vga_sync_decoder #(
    parameter int H_ACTIVE    = 640,
    parameter int V_ACTIVE    = 480,
    parameter int SYNC_POL    = 0,
    parameter int LOCK_FRAMES = 2,
    parameter int TIMEOUT_LN  = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pixel_tick,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic        video_on_in,
    output logic [9:0]  x_pos,
    output logic [9:0]  y_pos,
    output logic        pixel_valid,
    output logic        line_end,
    output logic        frame_start,
    output logic [10:0] h_meas,
    output logic [10:0] v_meas,
    output logic        locked,
    output logic        sync_err
);

    localparam int              TO_W   = $clog2(TIMEOUT_LN + 1);
    localparam logic [10:0]     H_EXP  = 11'(H_ACTIVE);
    localparam logic [10:0]     V_EXP  = 11'(V_ACTIVE);
    localparam logic [3:0]      LOCK_N = 4'(LOCK_FRAMES);
    localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT_LN);
    localparam logic            POL    = (SYNC_POL != 0) ? 1'b1 : 1'b0;

    typedef enum logic [1:0] {
        ST_SEARCH  = 2'd0,
        ST_ACQUIRE = 2'd1,
        ST_LOCKED  = 2'd2
    } state_t;

    function automatic logic [9:0] sat_inc10(input logic [9:0] v);
        return (v == 10'd1023) ? v : v + 10'd1;
    endfunction

    function automatic logic [10:0] sat_inc11(input logic [10:0] v);
        return (v == 11'd2047) ? v : v + 11'd1;
    endfunction

    state_t          state_r, state_s;
    logic [3:0]      match_r, match_s;
    logic            primed_r, primed_s;
    logic            prev_hs_r, prev_hs_s, prev_vs_r, prev_vs_s, prev_de_r, prev_de_s;
    logic            seen_r, seen_s;
    logic [9:0]      x_r, x_s, y_r, y_s;
    logic [10:0]     hcnt_r, hcnt_s, vcnt_r, vcnt_s;
    logic [10:0]     h_meas_r, h_meas_s, v_meas_r, v_meas_s;
    logic [TO_W-1:0] to_r, to_s;
    logic            line_bad_r, line_bad_s;
    logic            locked_r, locked_s;
    logic            pv_r, pv_s, le_r, le_s, fs_r, fs_s, err_r, err_s;
    logic            timeout_s, frame_good_s;

    logic hs_act_s, vs_act_s, live_s, hs_edge_s, vs_edge_s, de_tick_s, de_fall_s;

    // Polarity-normalised sync levels; edges exist only once the previous-sample copy is valid.
    assign hs_act_s     = (hsync_in == POL);
    assign vs_act_s     = (vsync_in == POL);
    assign live_s       = pixel_tick & primed_r;
    assign hs_edge_s    = live_s & hs_act_s & ~prev_hs_r;
    assign vs_edge_s    = live_s & vs_act_s & ~prev_vs_r;
    assign de_tick_s    = live_s & video_on_in;
    assign de_fall_s    = live_s & prev_de_r & ~video_on_in;
    assign frame_good_s = ~line_bad_r & (vcnt_r == V_EXP);

    // Next-state for counters, measurements, strobes and the lock FSM.
    always_comb begin
        state_s    = state_r;
        match_s    = match_r;
        primed_s   = primed_r;
        prev_hs_s  = prev_hs_r;
        prev_vs_s  = prev_vs_r;
        prev_de_s  = prev_de_r;
        seen_s     = seen_r;
        x_s        = x_r;
        y_s        = y_r;
        hcnt_s     = hcnt_r;
        vcnt_s     = vcnt_r;
        h_meas_s   = h_meas_r;
        v_meas_s   = v_meas_r;
        to_s       = to_r;
        line_bad_s = line_bad_r;
        locked_s   = locked_r;
        pv_s       = 1'b0;
        le_s       = 1'b0;
        fs_s       = 1'b0;
        err_s      = de_tick_s & vs_act_s;
        timeout_s  = 1'b0;

        if (pixel_tick) begin
            primed_s  = 1'b1;
            prev_hs_s = hs_act_s;
            prev_vs_s = vs_act_s;
            prev_de_s = video_on_in;
        end else begin
            primed_s  = primed_r;
        end

        if (de_tick_s) begin
            pv_s = seen_r;
            if (prev_de_r) begin
                x_s    = sat_inc10(x_r);
                hcnt_s = sat_inc11(hcnt_r);
            end else begin
                x_s    = 10'd0;
                hcnt_s = 11'd1;
            end
        end else begin
            pv_s = 1'b0;
        end

        if (de_fall_s) begin
            le_s       = 1'b1;
            h_meas_s   = hcnt_r;
            y_s        = sat_inc10(y_r);
            vcnt_s     = sat_inc11(vcnt_r);
            line_bad_s = line_bad_r | (hcnt_r != H_EXP);
        end else begin
            le_s = 1'b0;
        end

        if (hs_edge_s && (to_r != TO_MAX)) begin
            to_s      = to_r + TO_W'(1);
            timeout_s = (to_r == (TO_MAX - TO_W'(1)));
        end else begin
            timeout_s = 1'b0;
        end

        // A vsync edge always clears the line timeout, so it takes priority.
        if (vs_edge_s) begin
            fs_s       = 1'b1;
            seen_s     = 1'b1;
            v_meas_s   = vcnt_r;
            y_s        = 10'd0;
            vcnt_s     = 11'd0;
            to_s       = '0;
            line_bad_s = 1'b0;
            case (state_r)
                ST_SEARCH: begin
                    state_s = ST_ACQUIRE;
                    match_s = 4'd0;
                end
                ST_ACQUIRE: begin
                    if (!frame_good_s) begin
                        match_s = 4'd0;
                        err_s   = 1'b1;
                    end else if ((match_r + 4'd1) == LOCK_N) begin
                        state_s  = ST_LOCKED;
                        match_s  = 4'd0;
                        locked_s = 1'b1;
                    end else begin
                        match_s = match_r + 4'd1;
                    end
                end
                ST_LOCKED: begin
                    if (!frame_good_s) begin
                        state_s  = ST_ACQUIRE;
                        match_s  = 4'd0;
                        locked_s = 1'b0;
                        err_s    = 1'b1;
                    end else begin
                        state_s  = ST_LOCKED;
                    end
                end
                default: begin
                    state_s  = ST_SEARCH;
                    match_s  = 4'd0;
                    locked_s = 1'b0;
                end
            endcase
        end else if (timeout_s) begin
            state_s  = ST_SEARCH;
            match_s  = 4'd0;
            locked_s = 1'b0;
            seen_s   = 1'b0;
            err_s    = 1'b1;
        end else begin
            fs_s = 1'b0;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r    <= ST_SEARCH;
            match_r    <= 4'd0;
            primed_r   <= 1'b0;
            prev_hs_r  <= 1'b0;
            prev_vs_r  <= 1'b0;
            prev_de_r  <= 1'b0;
            seen_r     <= 1'b0;
            x_r        <= 10'd0;
            y_r        <= 10'd0;
            hcnt_r     <= 11'd0;
            vcnt_r     <= 11'd0;
            h_meas_r   <= 11'd0;
            v_meas_r   <= 11'd0;
            to_r       <= '0;
            line_bad_r <= 1'b0;
            locked_r   <= 1'b0;
            pv_r       <= 1'b0;
            le_r       <= 1'b0;
            fs_r       <= 1'b0;
            err_r      <= 1'b0;
        end else begin
            state_r    <= state_s;
            match_r    <= match_s;
            primed_r   <= primed_s;
            prev_hs_r  <= prev_hs_s;
            prev_vs_r  <= prev_vs_s;
            prev_de_r  <= prev_de_s;
            seen_r     <= seen_s;
            x_r        <= x_s;
            y_r        <= y_s;
            hcnt_r     <= hcnt_s;
            vcnt_r     <= vcnt_s;
            h_meas_r   <= h_meas_s;
            v_meas_r   <= v_meas_s;
            to_r       <= to_s;
            line_bad_r <= line_bad_s;
            locked_r   <= locked_s;
            pv_r       <= pv_s;
            le_r       <= le_s;
            fs_r       <= fs_s;
            err_r      <= err_s;
        end
    end

    assign x_pos       = x_r;
    assign y_pos       = y_r;
    assign pixel_valid = pv_r;
    assign line_end    = le_r;
    assign frame_start = fs_r;
    assign h_meas      = h_meas_r;
    assign v_meas      = v_meas_r;
    assign locked      = locked_r;
    assign sync_err    = err_r;

endmodule
